// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and helpers for the bit-serial subtractor.
//   state_t   - controller states (IDLE, SHIFT, DONE)
//   cnt_width - bit counter width derived from the operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that must reach w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: single-bit combinational subtractor cell, a - b - bin.
//   a, b  - operand bits
//   bin   - borrow in
//   diff  - difference bit
//   bout  - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow propagates.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, a - b - bin, LSB first,
// one bit per clock through a single full_subtractor cell.
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid/in_ready    - operand channel (in_a, in_b, in_bin)
//   out_valid/out_ready  - result channel (out_diff, out_borrow)
//   out_ovf              - signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    logic             bw;
    logic [CW-1:0]    cnt;
    logic             diff_bit, bw_next;
    logic             last;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bw),
        .diff (diff_bit),
        .bout (bw_next)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // Handshake outputs depend on state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            out_ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= in_a;
                        b_sr <= in_b;
                        bw   <= in_bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= {diff_bit, r_sr[WIDTH-1:1]};
                    bw   <= bw_next;
                    if (last) begin
                        // Result outputs change only here, so they hold the
                        // previous answer for the whole shift phase.
                        out_diff   <= {diff_bit, r_sr[WIDTH-1:1]};
                        out_borrow <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
                        // a_sr[0]/b_sr[0] are the operand MSBs on the last bit.
                        out_ovf    <= (a_sr[0] != b_sr[0]) && (diff_bit != a_sr[0]);
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_diff;
    logic         out_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         out_ovf;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [W-1:0] prev_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_bin     (in_bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        logic [W:0] t;
        int s;
        t    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d  = t[W-1:0];
        e.br = t[W];
        s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.ov = (s > 127) || (s < -128);
        return e;
    endfunction

    // Drive one operation and wait for the accepting edge; pushes the model result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        in_a = a; in_b = b; in_bin = bin; in_valid = 1'b1;
        sb.push_back(model(a, b, bin));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_diff !== '0 || out_borrow !== 1'b0) begin
            n_err++;
            $display("FAIL reset: in_ready=%b out_valid=%b diff=%h borrow=%b, want 1 0 00 0",
                     in_ready, out_valid, out_diff, out_borrow);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_cmp++;
        if (out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b want 0", out_ovf);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends one operation, checks latency, hold-during-shift and result.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n;
        exp_t e;
        send(a, b, bin);
        n = 0;
        // Sample #1 after each rising edge following the accepting edge.
        while (n < 40) begin
            n++;
            if (n == 4) begin
                n_cmp++;
                if (out_diff !== prev_diff || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_hold: diff=%h in_ready=%b, want %h 0", nm, out_diff, in_ready, prev_diff);
                end
            end
            if (out_valid) break;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n - 1 != W) begin
            n_err++;
            $display("FAIL %s_latency: got %0d edges want %0d", nm, n - 1, W);
        end
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_scoreboard: empty queue, want 1 entry", nm);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (out_diff !== e.d || out_borrow !== e.br) begin
                n_err++;
                $display("FAIL %s_result: diff=%h borrow=%b want %h %b", nm, out_diff, out_borrow, e.d, e.br);
            end
`ifdef SERIAL_SUB_OVF_EN
            n_cmp++;
            if (out_ovf !== e.ov) begin
                n_err++;
                $display("FAIL %s_ovf: got %b want %b", nm, out_ovf, e.ov);
            end
`endif
            prev_diff = e.d;
        end
        if (out_ready) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s_release: out_valid=%b in_ready=%b want 0 1", nm, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        run_op("sub_5_3", 8'h05, 8'h03, 1'b0);
        run_op("sub_3_5", 8'h03, 8'h05, 1'b0);
        run_op("zero_bin", 8'h00, 8'h00, 1'b1);
        run_op("ovf_80_01", 8'h80, 8'h01, 1'b0);
        run_op("equal", 8'hA7, 8'hA7, 1'b0);
    endtask

    task automatic test_backpressure;
        exp_t e;
        out_ready = 1'b0;
        run_op("bp", 8'h5A, 8'h21, 1'b0);
        e = model(8'h5A, 8'h21, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_a = 8'hFF - 8'(i); in_b = 8'(i); in_bin = 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_diff !== e.d || out_borrow !== e.br || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall%0d: valid=%b diff=%h borrow=%b in_ready=%b want 1 %h %b 0",
                         i, out_valid, out_diff, out_borrow, in_ready, e.d, e.br);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        // Nothing captured during the stall: a fresh op must be exact.
        run_op("bp_after", 8'h10, 8'h01, 1'b1);
    endtask

    task automatic test_reset_mid_shift;
        send(8'h33, 8'h11, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_diff !== '0 || out_borrow !== 1'b0) begin
            n_err++;
            $display("FAIL midreset: in_ready=%b out_valid=%b diff=%h borrow=%b want 1 0 00 0",
                     in_ready, out_valid, out_diff, out_borrow);
        end
        sb.delete();
        prev_diff = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset", 8'h7F, 8'hFF, 1'b0);
    endtask

    task automatic test_back_to_back;
        int sent, got, last_acc;
        exp_t e;
        sent = 0; got = 0; last_acc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 12; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_scoreboard: empty queue at result %0d", got);
                end else begin
                    e = sb.pop_front();
                    if (out_diff !== e.d || out_borrow !== e.br) begin
                        n_err++;
                        $display("FAIL b2b_result%0d: diff=%h borrow=%b want %h %b",
                                 got, out_diff, out_borrow, e.d, e.br);
                    end
                end
                got++;
            end
            if (in_ready && sent < 12) begin
                in_a = 8'($urandom_range(0, 255));
                in_b = 8'($urandom_range(0, 255));
                in_bin = 1'($urandom_range(0, 1));
                sb.push_back(model(in_a, in_b, in_bin));
                if (sent > 0) begin
                    n_cmp++;
                    if (cyc - last_acc != W + 2) begin
                        n_err++;
                        $display("FAIL b2b_rate%0d: got %0d cycles want %0d", sent, cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
                sent++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 12) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 12", got);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_reset_mid_shift;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
